// File: rtl/rr_mux_pkg.sv
// Shared helpers for the round-robin gather multiplexer.
package rr_mux_pkg;

  // Advance a round-robin pointer by one position, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_mux_if.sv
// Bundle of the N source channels and the single output stream of rr_mux.
interface rr_mux_if #(
  parameter int N_MASTERS  = 4,
  parameter int DATA_WIDTH = 4
);
  localparam int SEL_W = $clog2(N_MASTERS);

  logic [N_MASTERS-1:0]            in_valid;
  logic [DATA_WIDTH*N_MASTERS-1:0] in_data;
  logic [N_MASTERS-1:0]            in_ready;
  logic                            out_valid;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [SEL_W-1:0]                out_sel;
  logic                            out_ready;

  // The multiplexer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  // The sources and sink surrounding the multiplexer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_pick.sv
// Combinational round-robin picker: rotate requests by prio, then find first set.
module rr_pick #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] prio,
  output logic [N-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);
  localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(N);

  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;
  logic [SEL_W:0]   sum;

  // Doubling the vector makes the wrap from N-1 back to 0 a plain shift.
  assign rot = N'({req, req} >> prio);
  assign any = |req;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign sum     = {1'b0, prio} + {1'b0, off};
  assign gnt_idx = (sum >= N_W) ? SEL_W'(sum - N_W) : sum[SEL_W-1:0];

  always_comb begin
    gnt_onehot = '0;
    if (any) gnt_onehot[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/rr_mux.sv
// N-to-1 round-robin arbitrated multiplexer with a registered, source-tagged output.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int N_MASTERS  = 4,
  parameter int DATA_WIDTH = 4
) (
  input logic     clk,
  input logic     rst,
  rr_mux_if.slave bus
);
  localparam int SEL_W = $clog2(N_MASTERS);

  logic [N_MASTERS-1:0]  gnt_onehot;
  logic [SEL_W-1:0]      gnt_idx;
  logic                  any;
  logic                  load;
  logic                  accept;
  logic [SEL_W-1:0]      prio_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0]      out_sel_q;
  logic [DATA_WIDTH-1:0] lane [N_MASTERS];

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      lane[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rr_pick #(.N(N_MASTERS)) u_pick (
    .req        (bus.in_valid),
    .prio       (prio_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  // The register can take a beat when empty or when its beat leaves this cycle.
  assign load         = ~out_valid_q | bus.out_ready;
  assign accept       = any & load & ~rst;
  assign bus.in_ready = accept ? gnt_onehot : '0;

  // NOTE: sequential state uses non-blocking assignments; the data/sel registers
  // are reset too because their reset value of zero is observable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      prio_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= lane[gnt_idx];
      out_sel_q   <= gnt_idx;
      prio_q      <= SEL_W'(wrap_inc(int'(gnt_idx), N_MASTERS));
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux: directed vector table on a 4-source instance,
// randomized scoreboard run on a 3-source instance.
module tb_rr_mux;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_mux_if #(.N_MASTERS(4), .DATA_WIDTH(4)) bus4 ();
  rr_mux_if #(.N_MASTERS(3), .DATA_WIDTH(8)) bus3 ();

  rr_mux #(.N_MASTERS(4), .DATA_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  rr_mux #(.N_MASTERS(3), .DATA_WIDTH(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] data;
    logic        ordy;
    logic [3:0]  exp_ready;  // combinational, before the edge
    logic        exp_ov;     // registered, after the edge
    logic [1:0]  exp_sel;
    logic [3:0]  exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [15:0] d, input logic o,
                     input logic [3:0] er, input logic eov, input logic [1:0] es,
                     input logic [3:0] ed);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.ordy = o;
    t.exp_ready = er; t.exp_ov = eov; t.exp_sel = es; t.exp_data = ed;
    vecs.push_back(t);
  endtask

  // Random-run state for the 3-source instance.
  logic [2:0] v3;
  logic [7:0] d3 [3];
  logic       ordy3;
  logic [9:0] sb [$];  // {sel, data}
  logic [9:0] exp_beat;
  logic [2:0] exp_r;
  logic       load_m;
  int seq_in [3], seq_out [3], wait_cnt [3], n_in [3], n_out [3];
  int m_prio, g, acc, s;

  localparam logic [15:0] D = 16'hBA98;

  initial begin
    rst            = 1'b1;
    bus4.in_valid  = '0;
    bus4.in_data   = D;
    bus4.out_ready = 1'b0;
    bus3.in_valid  = '0;
    bus3.in_data   = '0;
    bus3.out_ready = 1'b0;

    //   rst   valid  data      ordy  ready  ov    sel    data
    // reset with all sources requesting
    add(1'b1, 4'hF, D,        1'b1, 4'h0, 1'b0, 2'd0, 4'h0);
    add(1'b1, 4'hF, D,        1'b1, 4'h0, 1'b0, 2'd0, 4'h0);
    // full rotation, one beat per cycle
    add(1'b0, 4'hF, D,        1'b1, 4'h1, 1'b1, 2'd0, 4'h8);
    add(1'b0, 4'hF, D,        1'b1, 4'h2, 1'b1, 2'd1, 4'h9);
    add(1'b0, 4'hF, D,        1'b1, 4'h4, 1'b1, 2'd2, 4'hA);
    add(1'b0, 4'hF, D,        1'b1, 4'h8, 1'b1, 2'd3, 4'hB);
    add(1'b0, 4'hF, D,        1'b1, 4'h1, 1'b1, 2'd0, 4'h8);
    // backpressure: beat held, nothing accepted, requests may change
    add(1'b0, 4'hF, D,        1'b0, 4'h0, 1'b1, 2'd0, 4'h8);
    add(1'b0, 4'hF, D,        1'b0, 4'h0, 1'b1, 2'd0, 4'h8);
    add(1'b0, 4'h6, D,        1'b0, 4'h0, 1'b1, 2'd0, 4'h8);
    add(1'b0, 4'h8, D,        1'b0, 4'h0, 1'b1, 2'd0, 4'h8);
    add(1'b0, 4'hF, D,        1'b0, 4'h0, 1'b1, 2'd0, 4'h8);
    // drain with no requests: valid drops, data/sel hold
    add(1'b0, 4'h0, D,        1'b1, 4'h0, 1'b0, 2'd0, 4'h8);
    // sparse: only source 2 (prio=1)
    add(1'b0, 4'h4, 16'hB598, 1'b1, 4'h4, 1'b1, 2'd2, 4'h5);
    // sources 0 and 3 together with prio=3
    add(1'b0, 4'h9, D,        1'b1, 4'h8, 1'b1, 2'd3, 4'hB);
    add(1'b0, 4'h1, D,        1'b1, 4'h1, 1'b1, 2'd0, 4'h8);
    // mid-stream reset with a held beat and prio=1
    add(1'b0, 4'hF, D,        1'b0, 4'h0, 1'b1, 2'd0, 4'h8);
    add(1'b1, 4'hF, D,        1'b0, 4'h0, 1'b0, 2'd0, 4'h0);
    add(1'b0, 4'hF, D,        1'b0, 4'h1, 1'b1, 2'd0, 4'h8);
    add(1'b0, 4'hE, D,        1'b1, 4'h2, 1'b1, 2'd1, 4'h9);
    add(1'b0, 4'h0, D,        1'b1, 4'h0, 1'b0, 2'd1, 4'h9);

    @(posedge clk);
    #1;
    for (int k = 0; k < vecs.size(); k++) begin
      rst            = vecs[k].rst;
      bus4.in_valid  = vecs[k].valid;
      bus4.in_data   = vecs[k].data;
      bus4.out_ready = vecs[k].ordy;
      @(negedge clk);
      check($sformatf("v%0d in_ready", k), 32'(bus4.in_ready), 32'(vecs[k].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", k), 32'(bus4.out_valid), 32'(vecs[k].exp_ov));
      check($sformatf("v%0d out_sel", k),   32'(bus4.out_sel),   32'(vecs[k].exp_sel));
      check($sformatf("v%0d out_data", k),  32'(bus4.out_data),  32'(vecs[k].exp_data));
    end
    rst           = 1'b0;
    bus4.in_valid = '0;

    // Randomized run on the 3-source instance; the last cycles only drain.
    v3     = '0;
    m_prio = 0;
    for (int i = 0; i < 3; i++) begin
      seq_in[i] = 0; seq_out[i] = 0; wait_cnt[i] = 0; n_in[i] = 0; n_out[i] = 0;
      d3[i] = '0;
    end
    for (int cyc = 0; cyc < 2008; cyc++) begin
      if (cyc < 2000) begin
        for (int i = 0; i < 3; i++) begin
          if (!v3[i] && $urandom_range(2) == 0) begin
            v3[i] = 1'b1;
            d3[i] = {2'(i), 6'(seq_in[i])};
          end
        end
        ordy3 = ($urandom_range(3) != 0);
      end else begin
        ordy3 = 1'b1;
      end
      bus3.in_valid  = v3;
      bus3.in_data   = {d3[2], d3[1], d3[0]};
      bus3.out_ready = ordy3;

      @(negedge clk);
      g = -1;
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && v3[(m_prio + k) % 3]) g = (m_prio + k) % 3;
      end
      load_m = (sb.size() == 0) || ordy3;
      exp_r  = (g >= 0 && load_m) ? 3'(1 << g) : 3'b000;
      check("rand in_ready", 32'(bus3.in_ready), 32'(exp_r));
      check("rand out_valid", 32'(bus3.out_valid), 32'(sb.size() != 0));

      if (bus3.out_valid && ordy3 && sb.size() != 0) begin
        exp_beat = sb.pop_front();
        s = int'(exp_beat[9:8]);
        check("rand out_sel", 32'(bus3.out_sel), 32'(exp_beat[9:8]));
        check("rand out_data", 32'(bus3.out_data), 32'(exp_beat[7:0]));
        check("rand order", 32'(bus3.out_data), 32'({2'(s), 6'(seq_out[s])}));
        seq_out[s]++;
        n_out[s]++;
      end

      acc = -1;
      if (g >= 0 && load_m) begin
        sb.push_back({2'(g), d3[g]});
        check("rand fairness", 32'(wait_cnt[g] <= 2), 32'd1);
        wait_cnt[g] = 0;
        for (int j = 0; j < 3; j++) begin
          if (j != g && v3[j]) wait_cnt[j]++;
        end
        n_in[g]++;
        seq_in[g]++;
        m_prio = (g + 1) % 3;
        acc    = g;
      end

      @(posedge clk);
      #1;
      if (acc >= 0) v3[acc] = 1'b0;
    end

    check("rand drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rand count src%0d", i), 32'(n_out[i]), 32'(n_in[i]));
      check($sformatf("rand activity src%0d", i), 32'(n_in[i] > 50), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
